apb_mem_slave: RTL and testbench

Parametrised APB4 completer with a byte-strobed word memory and run-time programmable wait states. It reports errors for misaligned and out-of-range accesses. It connects on the slave side of the existing APB interface and is the next-generation DUT for the APB UVM environment. Relative to the plain APB3 slave signal set, it adds PSTRB, PPROT, configurable depth, and wait-state insertion.

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_wait_ctr.sv | 18 +
 rtl/apb_mem_slave.sv | 115 +++++++++++
 tb/tb_apb_mem_slave.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, protection attribute layout and bus-width helpers
package apb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, READY} apb_state_e;
  typedef struct packed {
    logic instr;
    logic nonsec;
    logic priv;
  } apb_prot_t;
  function automatic int calc_align(input int data_width);
    return $clog2(data_width / 8);
  endfunction
endpackage

// File: rtl/apb_wait_ctr.sv
// apb_wait_ctr: loadable down-counter flagging the last wait state
module apb_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins over decrement; count saturates at zero
  always_comb cnt_d = load ? val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign done = cnt_q == W'(1);
endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB4 completer with byte-strobed word memory and programmable wait states
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int WAIT_W     = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  input  logic [WAIT_W-1:0]       cfg_wait,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  localparam int ALIGN = calc_align(DATA_WIDTH);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'((1 << ALIGN) - 1);

  apb_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, cur_addr, idx, widx;
  logic [DATA_WIDTH-1:0] wdata_q, prdata_q, prdata_d, rd_word;
  logic [SW-1:0] strb_q;
  apb_prot_t prot_q;
  logic write_q, err_q, pready_q, pready_d, pslverr_q, pslverr_d;
  logic setup, cur_write, cur_err, go_ready, done, mem_we;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // setup uses the live bus; later phases use the captured transfer
  assign setup     = state_q == IDLE && PSEL && !PENABLE;
  assign cur_addr  = setup ? PADDR : addr_q;
  assign cur_write = setup ? PWRITE : write_q;
  assign idx       = cur_addr >> ALIGN;
  assign cur_err   = (cur_addr & AMASK) != '0 || idx >= ADDR_WIDTH'(DEPTH);
  assign rd_word   = mem_q[idx[IW-1:0]];
  assign go_ready  = (setup && cfg_wait == '0) || (state_q == WAIT && PSEL && done);
  assign widx      = addr_q >> ALIGN;
  assign mem_we    = state_q == READY && PSEL && PENABLE && pready_q && write_q && !err_q;

  apb_wait_ctr #(.W(WAIT_W)) u_wait (
    .clk (PCLK),
    .rst (PRESET),
    .load(setup),
    .en  (state_q == WAIT),
    .val (cfg_wait),
    .done(done)
  );

  // next state and registered response; READY always lasts one cycle
  always_comb begin
    state_d   = state_q;
    pready_d  = go_ready;
    pslverr_d = go_ready && cur_err;
    prdata_d  = go_ready ? ((cur_write || cur_err) ? '0 : rd_word) : prdata_q;
    state_d   = state_q == IDLE ? (setup ? (cfg_wait == '0 ? READY : WAIT) : IDLE) :
                state_q == WAIT ? (!PSEL ? IDLE : done ? READY : WAIT) : IDLE;
  end

  // state and response registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // capture the transfer at setup
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      err_q   <= 1'b0;
    end else if (setup) begin
      addr_q  <= PADDR;
      write_q <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
      prot_q  <= apb_prot_t'(PPROT);
      err_q   <= cur_err;
    end
  end

  // memory: cleared on reset, strobed byte-lane write at completion
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < SW; b++)
        if (strb_q[b]) mem_q[widx[IW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: directed scenario tests for apb_mem_slave
module tb_apb_mem_slave;
  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [15:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [2:0]  PPROT = '0;
  logic [3:0]  cfg_wait = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  int total = 0;
  int bad = 0;

  apb_mem_slave dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .cfg_wait(cfg_wait),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // one full transfer, entered and left just after a rising edge
  task automatic xfer(input logic [15:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [3:0] wt,
                      output logic [31:0] rd, output logic er, output int waits);
    PSEL = 1; PENABLE = 0; PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s;
    PPROT = 3'b010; cfg_wait = wt;
    @(posedge PCLK); #1;
    PENABLE = 1;
    waits = 0;
    forever begin
      @(negedge PCLK);
      if (PREADY) break;
      waits++;
      if (waits > 40) break;
    end
    rd = PRDATA; er = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 0;
    @(negedge PCLK);
    total++;
    if ({PRDATA, PREADY, PSLVERR} !== 34'h0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {PRDATA, PREADY, PSLVERR});
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset_reads;
    logic [31:0] rd; logic er; int w;
    for (int i = 0; i < 16; i++) begin
      xfer(16'(i * 4), 0, 0, 4'hF, 0, rd, er, w);
      total++;
      if (rd !== 0 || er !== 0 || w !== 0) begin
        bad++; $display("FAIL reset_read idx=%0d data=%h err=%b waits=%0d exp 0/0/0", i, rd, er, w);
      end
    end
  endtask

  task automatic test_strobe;
    logic [31:0] rd; logic er; int w;
    xfer(16'h0008, 1, 32'hDEADBEEF, 4'b0101, 0, rd, er, w);
    total++;
    if (er !== 0 || rd !== 0) begin
      bad++; $display("FAIL strobe_write err=%b data=%h exp 0/0", er, rd);
    end
    xfer(16'h0008, 0, 0, 4'hF, 0, rd, er, w);
    total++;
    if (rd !== 32'h00AD00EF || er !== 0) begin
      bad++; $display("FAIL strobe_read data=%h err=%b exp 00ad00ef/0", rd, er);
    end
    xfer(16'h0014, 1, 32'hFFFFFFFF, 4'b0000, 0, rd, er, w);
    total++;
    if (er !== 0) begin
      bad++; $display("FAIL zero_strb_err got=%b exp=0", er);
    end
    xfer(16'h0014, 0, 0, 4'hF, 0, rd, er, w);
    total++;
    if (rd !== 0) begin
      bad++; $display("FAIL zero_strb_read got=%h exp=0", rd);
    end
  endtask

  task automatic test_wait;
    logic [31:0] rd; logic er; int w;
    xfer(16'h0004, 0, 0, 4'hF, 3, rd, er, w);
    total++;
    if (w !== 3 || rd !== 0 || er !== 0) begin
      bad++; $display("FAIL wait3 waits=%0d data=%h err=%b exp 3/0/0", w, rd, er);
    end
    xfer(16'h0008, 0, 0, 4'hF, 1, rd, er, w);
    total++;
    if (w !== 1 || rd !== 32'h00AD00EF) begin
      bad++; $display("FAIL wait1 waits=%0d data=%h exp 1/00ad00ef", w, rd);
    end
    xfer(16'h0008, 0, 0, 4'hF, 15, rd, er, w);
    total++;
    if (w !== 15 || rd !== 32'h00AD00EF) begin
      bad++; $display("FAIL wait15 waits=%0d data=%h exp 15/00ad00ef", w, rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int w;
    xfer(16'h0040, 1, 32'h11111111, 4'hF, 0, rd, er, w);
    total++;
    if (er !== 1 || rd !== 0) begin
      bad++; $display("FAIL oor_write err=%b data=%h exp 1/0", er, rd);
    end
    xfer(16'h0002, 1, 32'h22222222, 4'hF, 2, rd, er, w);
    total++;
    if (er !== 1 || rd !== 0 || w !== 2) begin
      bad++; $display("FAIL misaligned_write err=%b data=%h waits=%0d exp 1/0/2", er, rd, w);
    end
    xfer(16'h0000, 0, 0, 4'hF, 0, rd, er, w);
    total++;
    if (rd !== 0 || er !== 0) begin
      bad++; $display("FAIL misaligned_readback data=%h err=%b exp 0/0", rd, er);
    end
    xfer(16'h0008, 0, 0, 4'hF, 0, rd, er, w);
    xfer(16'h0040, 0, 0, 4'hF, 0, rd, er, w);
    total++;
    if (er !== 1 || rd !== 0) begin
      bad++; $display("FAIL oor_read err=%b data=%h exp 1/0", er, rd);
    end
    xfer(16'h0009, 0, 0, 4'hF, 0, rd, er, w);
    total++;
    if (er !== 1 || rd !== 0) begin
      bad++; $display("FAIL misaligned_read err=%b data=%h exp 1/0", er, rd);
    end
    xfer(16'h0008, 0, 0, 4'hF, 0, rd, er, w);
    total++;
    if (rd !== 32'h00AD00EF || er !== 0) begin
      bad++; $display("FAIL err_ok_after data=%h err=%b exp 00ad00ef/0", rd, er);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int w;
    xfer(16'h000C, 1, 32'h12345678, 4'hF, 0, rd, er, w);
    xfer(16'h000C, 0, 0, 4'hF, 0, rd, er, w);
    total++;
    if (rd !== 32'h12345678 || er !== 0 || w !== 0) begin
      bad++; $display("FAIL b2b_read data=%h err=%b waits=%0d exp 12345678/0/0", rd, er, w);
    end
    xfer(16'h003C, 1, 32'hCAFEF00D, 4'hF, 2, rd, er, w);
    xfer(16'h003C, 0, 0, 4'hF, 0, rd, er, w);
    total++;
    if (rd !== 32'hCAFEF00D) begin
      bad++; $display("FAIL b2b_last_word data=%h exp cafef00d", rd);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int w;
    PSEL = 1; PENABLE = 0; PADDR = 16'h0010; PWRITE = 1; PWDATA = 32'hA5A5A5A5;
    PSTRB = 4'hF; cfg_wait = 5;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #1;
    PRESET = 1;
    @(posedge PCLK); #1;
    PRESET = 0; PSEL = 0; PENABLE = 0;
    @(negedge PCLK);
    total++;
    if ({PRDATA, PREADY, PSLVERR} !== 34'h0) begin
      bad++; $display("FAIL midreset_outputs got=%h exp=0", {PRDATA, PREADY, PSLVERR});
    end
    @(posedge PCLK); #1;
    xfer(16'h0010, 0, 0, 4'hF, 0, rd, er, w);
    total++;
    if (rd !== 0 || er !== 0) begin
      bad++; $display("FAIL midreset_readback data=%h err=%b exp 0/0", rd, er);
    end
    xfer(16'h000C, 0, 0, 4'hF, 0, rd, er, w);
    total++;
    if (rd !== 0) begin
      bad++; $display("FAIL midreset_memclear data=%h exp 0", rd);
    end
  endtask

  initial begin
    test_reset;
    test_reset_reads;
    test_strobe;
    test_wait;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
